// File: rtl/lcomp_pkg.sv
// Shared definitions for the lcomp limiter chain: state encoding, envelope widths, default precision.
package lcomp_pkg;

    localparam int LCOMP_FRAC_DEF = 8;
    localparam int LCOMP_SAMPLE_W = 8;
    localparam int LCOMP_MAG_W    = 7;
    localparam int LCOMP_ENV_W    = 8;

    typedef logic [LCOMP_ENV_W-1:0]           lcomp_env_t;
    typedef logic signed [LCOMP_SAMPLE_W-1:0] lcomp_sample_t;
    typedef logic [1:0]                       lcomp_state_t;

    localparam lcomp_state_t ST_ATTACK  = 2'd0;
    localparam lcomp_state_t ST_HOLD    = 2'd1;
    localparam lcomp_state_t ST_RELEASE = 2'd2;

endpackage

// File: rtl/lcomp_envelope_if.sv
// Sample-in / sample+envelope-out bundle between the audio source, envelope detector and compressor.
interface lcomp_envelope_if;
    import lcomp_pkg::*;

    logic                      i_valid;
    logic [LCOMP_SAMPLE_W-1:0] i_data;
    logic                      o_valid;
    logic [LCOMP_SAMPLE_W-1:0] o_data;
    lcomp_env_t                o_env;
    lcomp_state_t              o_state;

    modport master (output i_valid, i_data, input o_valid, o_data, o_env, o_state);
    modport slave  (input i_valid, i_data, output o_valid, o_data, o_env, o_state);

endinterface

// File: rtl/lcomp_abs_sat.sv
// Signed 8-bit sample to 7-bit magnitude; -128 saturates to 127. Purely combinational.
module lcomp_abs_sat
    import lcomp_pkg::*;
(
    input  lcomp_sample_t          sample,
    output logic [LCOMP_MAG_W-1:0] mag
);

    logic [LCOMP_SAMPLE_W-1:0] neg;

    assign neg = ~sample + 8'd1;

    always_comb begin
        mag = sample[6:0];
        if (sample[7]) begin
            mag = (sample == 8'sh80) ? 7'h7f : neg[6:0];
        end
    end

endmodule

// File: rtl/lcomp_envelope.sv
// Peak envelope follower with attack/hold/release; 1-cycle latency, sample delayed to match.
// No backpressure: every accepted sample yields exactly one o_valid beat on the next cycle.
module lcomp_envelope
    import lcomp_pkg::*;
#(
    parameter int ATTACK_SHIFT  = 1,
    parameter int RELEASE_SHIFT = 4,
    parameter int HOLD_SAMPLES  = 4,
    parameter int FRAC          = LCOMP_FRAC_DEF
)(
    input logic             i_clk,
    input logic             i_reset_n,
    lcomp_envelope_if.slave bus
);

    localparam int EW = LCOMP_ENV_W + FRAC;

    logic [LCOMP_MAG_W-1:0]    mag;
    logic [EW-1:0]             m_val;
    logic [EW-1:0]             env_q, env_d;
    logic [EW-1:0]             step_up, step_dn;
    logic [7:0]                hold_q, hold_d;
    lcomp_state_t              st_q, st_d;
    logic                      vld_q;
    logic [LCOMP_SAMPLE_W-1:0] dat_q;

    lcomp_abs_sat u_abs (
        .sample (bus.i_data),
        .mag    (mag)
    );

    assign m_val   = {1'b0, mag, {FRAC{1'b0}}};
    assign step_up = (m_val - env_q) >> ATTACK_SHIFT;
    assign step_dn = (env_q - m_val) >> RELEASE_SHIFT;

    // Minimum step of one LSB lets E land exactly on M instead of stalling short of it.
    always_comb begin
        env_d  = env_q;
        hold_d = hold_q;
        st_d   = st_q;
        if (bus.i_valid) begin
            if (m_val > env_q) begin
                env_d  = env_q + ((step_up == '0) ? EW'(1) : step_up);
                hold_d = 8'(HOLD_SAMPLES);
                st_d   = ST_ATTACK;
            end else if (hold_q != 8'd0) begin
                hold_d = hold_q - 8'd1;
                st_d   = ST_HOLD;
            end else begin
                env_d  = env_q - ((step_dn == '0 && env_q > m_val) ? EW'(1) : step_dn);
                st_d   = ST_RELEASE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            env_q  <= '0;
            hold_q <= 8'd0;
            st_q   <= ST_RELEASE;
            vld_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            env_q  <= env_d;
            hold_q <= hold_d;
            st_q   <= st_d;
            vld_q  <= bus.i_valid;
            if (bus.i_valid) begin
                dat_q <= bus.i_data;
            end
        end
    end

    assign bus.o_valid = vld_q;
    assign bus.o_data  = dat_q;
    assign bus.o_env   = env_q[FRAC+7:FRAC];
    assign bus.o_state = st_q;

endmodule

// File: tb/tb_lcomp_envelope.sv
// Bench for lcomp_envelope: three parameterisations driven by one stimulus stream, checked
// every cycle against an integer model of the attack/hold/release rules plus literal expectations.
module tb_lcomp_envelope;
    import lcomp_pkg::*;

    logic       i_clk     = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       tb_valid  = 1'b0;
    logic [7:0] tb_data   = 8'd0;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    lcomp_envelope_if ifa();
    lcomp_envelope_if ifb();
    lcomp_envelope_if ifc();

    assign ifa.i_valid = tb_valid;
    assign ifa.i_data  = tb_data;
    assign ifb.i_valid = tb_valid;
    assign ifb.i_data  = tb_data;
    assign ifc.i_valid = tb_valid;
    assign ifc.i_data  = tb_data;

    lcomp_envelope #(.ATTACK_SHIFT(1), .RELEASE_SHIFT(4), .HOLD_SAMPLES(4), .FRAC(8))
        dut_a (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(ifa));
    lcomp_envelope #(.ATTACK_SHIFT(0), .RELEASE_SHIFT(4), .HOLD_SAMPLES(4), .FRAC(8))
        dut_b (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(ifb));
    lcomp_envelope #(.ATTACK_SHIFT(0), .RELEASE_SHIFT(4), .HOLD_SAMPLES(0), .FRAC(8))
        dut_c (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(ifc));

    // Reference model: envelope kept as a plain integer in units of 1/256.
    int ash[3]   = '{1, 0, 0};
    int hsamp[3] = '{4, 4, 0};
    int m_e[3]   = '{0, 0, 0};
    int m_hold[3] = '{0, 0, 0};
    int m_st[3]  = '{2, 2, 2};
    int m_vld    = 0;
    int m_dat    = 0;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < 3; k++) begin
                m_e[k] = 0; m_hold[k] = 0; m_st[k] = 2;
            end
            m_vld = 0;
            m_dat = 0;
        end else begin
            m_vld = int'(tb_valid);
            if (tb_valid) begin
                int s, mg, big, st;
                s  = int'($signed(tb_data));
                mg = (s < 0) ? -s : s;
                if (mg > 127) mg = 127;
                big = mg * 256;
                m_dat = int'(tb_data);
                for (int k = 0; k < 3; k++) begin
                    if (big > m_e[k]) begin
                        st = (big - m_e[k]) / (1 << ash[k]);
                        m_e[k] += (st == 0) ? 1 : st;
                        m_hold[k] = hsamp[k];
                        m_st[k] = 0;
                    end else if (m_hold[k] != 0) begin
                        m_hold[k]--;
                        m_st[k] = 1;
                    end else begin
                        st = (m_e[k] - big) / 16;
                        if (st == 0 && m_e[k] > big) st = 1;
                        m_e[k] -= st;
                        m_st[k] = 2;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic v, input logic [7:0] d,
                       input logic [7:0] e, input logic [1:0] s);
        chk($sformatf("cmp%0d_valid", k), int'(v), m_vld);
        chk($sformatf("cmp%0d_data", k),  int'(d), m_dat);
        chk($sformatf("cmp%0d_env", k),   int'(e), m_e[k] / 256);
        chk($sformatf("cmp%0d_state", k), int'(s), m_st[k]);
    endtask

    always @(negedge i_clk) begin
        cmp(0, ifa.o_valid, ifa.o_data, ifa.o_env, ifa.o_state);
        cmp(1, ifb.o_valid, ifb.o_data, ifb.o_env, ifb.o_state);
        cmp(2, ifc.o_valid, ifc.o_data, ifc.o_env, ifc.o_state);
    end

    // Drive one input cycle and return just after the edge that consumes it.
    task automatic beat(input logic v, input logic [7:0] d);
        @(negedge i_clk);
        #1;
        tb_valid = v;
        tb_data  = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        #1;
        i_reset_n = 1'b0;
        tb_valid  = 1'b0;
        @(negedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    int gap_env[3] = '{50, 75, 87};
    int hr_env[7]  = '{100, 100, 100, 100, 100, 93, 87};
    int hr_st[7]   = '{0, 1, 1, 1, 1, 2, 2};

    initial begin
        // Reset held with random activity on the inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            #1;
            tb_valid = 1'($urandom);
            tb_data  = 8'($urandom);
            #2;
            chk("rst_valid", int'(ifa.o_valid), 0);
            chk("rst_env",   int'(ifb.o_env), 0);
            chk("rst_data",  int'(ifa.o_data), 0);
            chk("rst_state", int'(ifc.o_state), 2);
        end
        @(negedge i_clk);
        #1;
        tb_valid  = 1'b0;
        i_reset_n = 1'b1;

        // Attack from zero
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 8'd100);
            chk("attack_env_a", int'(ifa.o_env), gap_env[i]);
            chk("attack_st_a",  int'(ifa.o_state), 0);
            chk("attack_vld_a", int'(ifa.o_valid), 1);
            chk("attack_env_b", int'(ifb.o_env), 100);
        end

        // Asynchronous reset between edges must clear outputs immediately
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("async_valid", int'(ifa.o_valid), 0);
        chk("async_env",   int'(ifa.o_env), 0);
        chk("async_data",  int'(ifa.o_data), 0);
        chk("async_state", int'(ifa.o_state), 2);
        @(negedge i_clk);
        #1;
        tb_valid  = 1'b0;
        i_reset_n = 1'b1;

        // Attack again with a bubble after every sample
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 8'd100);
            chk("gap_env",   int'(ifa.o_env), gap_env[i]);
            chk("gap_vld",   int'(ifa.o_valid), 1);
            beat(1'b0, 8'd55);
            chk("gap_idle_vld", int'(ifa.o_valid), 0);
            chk("gap_idle_env", int'(ifa.o_env), gap_env[i]);
            chk("gap_idle_st",  int'(ifa.o_state), 0);
            chk("gap_idle_dat", int'(ifa.o_data), 100);
        end

        // Saturation of the most negative sample
        do_reset();
        beat(1'b1, 8'h80);
        chk("sat_env",  int'(ifb.o_env), 127);
        chk("sat_data", int'(ifb.o_data), 8'h80);

        // Convergence down to a small steady level
        for (int i = 0; i < 2000; i++) begin
            beat(1'b1, 8'd3);
            if (i >= 1900) begin
                chk("conv_env_b", int'(ifb.o_env), 3);
                chk("conv_env_a", int'(ifa.o_env), 3);
                chk("conv_st_b",  int'(ifb.o_state), 2);
            end
        end

        // Hold then release; dut_c has no hold and releases at once
        do_reset();
        for (int i = 0; i < 7; i++) begin
            beat(1'b1, (i == 0) ? 8'd100 : 8'd0);
            chk("hr_env_b", int'(ifb.o_env), hr_env[i]);
            chk("hr_st_b",  int'(ifb.o_state), hr_st[i]);
            if (i == 1) begin
                chk("nohold_env_c", int'(ifc.o_env), 93);
                chk("nohold_st_c",  int'(ifc.o_state), 2);
            end
        end
        beat(1'b0, 8'd0);

        @(negedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
